// File: rtl/led_sweep_pkg.sv
// led_sweep_pkg: mode and FSM state encodings shared by the LED sweep generator.
package led_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_TRI    = 2'b00,
    MODE_SAW_UP = 2'b01,
    MODE_SAW_DN = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'b00,
    DWELL_TOP = 2'b01,
    RAMP_DOWN = 2'b10,
    DWELL_BOT = 2'b11
  } sweep_state_t;

endpackage

// File: rtl/led_sweep_step.sv
// led_sweep_step: saturating add (down=0) or subtract (down=1) of STEP against a limit.
// A zero step is treated as one so the sweep can never stall.
module led_sweep_step #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             down,
  output logic [WIDTH-1:0] result,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   floor_sum;

  always_comb begin
    step_eff  = (step == '0) ? ONE : step;
    sum       = {1'b0, data} + {1'b0, step_eff};
    floor_sum = {1'b0, limit} + {1'b0, step_eff};
    // data - step <= limit is tested as data <= limit + step to avoid underflow
    if (down)
      result = ({1'b0, data} <= floor_sum) ? limit : (data - step_eff);
    else
      result = (sum >= {1'b0, limit}) ? limit : sum[WIDTH-1:0];
    at_limit = (result == limit);
  end

endmodule

// File: rtl/led_sweep_gen.sv
// led_sweep_gen: programmable LED sweep (triangle / saw-up / saw-down / hold) with endpoint
// dwell and trigger pulses. Define LED_SWEEP_GAMMA_EN for a registered squared DATA_GAM.
module led_sweep_gen #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               CLOCK_IN,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [1:0]         MODE,
  input  logic [WIDTH-1:0]   STEP,
  input  logic [WIDTH-1:0]   LIMIT_LO,
  input  logic [WIDTH-1:0]   LIMIT_HI,
  input  logic [DWELL_W-1:0] DWELL,
  output logic [WIDTH-1:0]   DATA,
  output logic               DIR,
  output logic               TRIG_TOP,
  output logic               TRIG_BOT,
  output logic [WIDTH-1:0]   DATA_GAM
);

  import led_sweep_pkg::*;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  sweep_state_t       state_q;
  sweep_state_t       eff_state;
  mode_t              mode_s;
  logic [WIDTH-1:0]   data_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               dir_q;
  logic               trig_top_q;
  logic               trig_bot_q;
  logic [WIDTH-1:0]   up_res;
  logic [WIDTH-1:0]   dn_res;
  logic               up_hit;
  logic               dn_hit;
  logic               degenerate;

  assign mode_s     = mode_t'(MODE);
  assign degenerate = (LIMIT_LO >= LIMIT_HI);

  led_sweep_step #(.WIDTH(WIDTH)) u_step_up (
    .data     (data_q),
    .step     (STEP),
    .limit    (LIMIT_HI),
    .down     (1'b0),
    .result   (up_res),
    .at_limit (up_hit)
  );

  led_sweep_step #(.WIDTH(WIDTH)) u_step_dn (
    .data     (data_q),
    .step     (STEP),
    .limit    (LIMIT_LO),
    .down     (1'b1),
    .result   (dn_res),
    .at_limit (dn_hit)
  );

  // Saw modes redirect the current state onto their own half of the cycle.
  always_comb begin
    eff_state = state_q;
    if (mode_s == MODE_SAW_UP && (state_q == RAMP_DOWN || state_q == DWELL_BOT))
      eff_state = RAMP_UP;
    else if (mode_s == MODE_SAW_DN && (state_q == RAMP_UP || state_q == DWELL_TOP))
      eff_state = RAMP_DOWN;
  end

  always_ff @(posedge CLOCK_IN or posedge RESET) begin
    if (RESET) begin
      state_q    <= RAMP_UP;
      data_q     <= '0;
      dwell_cnt  <= '0;
      dir_q      <= 1'b0;
      trig_top_q <= 1'b0;
      trig_bot_q <= 1'b0;
    end else begin
      trig_top_q <= 1'b0;
      trig_bot_q <= 1'b0;
      if (ENABLE && mode_s != MODE_HOLD) begin
        if (degenerate) begin
          data_q <= LIMIT_LO;
        end else if (data_q < LIMIT_LO) begin
          data_q    <= LIMIT_LO;
          state_q   <= RAMP_UP;
          dir_q     <= 1'b0;
          dwell_cnt <= '0;
        end else if (data_q > LIMIT_HI) begin
          data_q    <= LIMIT_HI;
          dwell_cnt <= '0;
          if (mode_s == MODE_SAW_UP) begin
            state_q <= RAMP_UP;
            dir_q   <= 1'b0;
          end else begin
            state_q <= RAMP_DOWN;
            dir_q   <= 1'b1;
          end
        end else begin
          unique case (eff_state)
            RAMP_UP: begin
              data_q  <= up_res;
              dir_q   <= 1'b0;
              state_q <= RAMP_UP;
              if (up_hit) begin
                trig_top_q <= 1'b1;
                state_q    <= DWELL_TOP;
                dwell_cnt  <= '0;
              end
            end
            RAMP_DOWN: begin
              data_q  <= dn_res;
              dir_q   <= 1'b1;
              state_q <= RAMP_DOWN;
              if (dn_hit) begin
                trig_bot_q <= 1'b1;
                state_q    <= DWELL_BOT;
                dwell_cnt  <= '0;
              end
            end
            // Dwell exit performs the first step of the next leg in the same cycle.
            DWELL_TOP: begin
              if (dwell_cnt < DWELL) begin
                dwell_cnt <= dwell_cnt + DWELL_ONE;
              end else begin
                dwell_cnt <= '0;
                if (mode_s == MODE_SAW_UP) begin
                  data_q     <= LIMIT_LO;
                  trig_bot_q <= 1'b1;
                  state_q    <= RAMP_UP;
                  dir_q      <= 1'b0;
                end else begin
                  data_q     <= dn_res;
                  dir_q      <= 1'b1;
                  trig_bot_q <= dn_hit;
                  state_q    <= dn_hit ? DWELL_BOT : RAMP_DOWN;
                end
              end
            end
            DWELL_BOT: begin
              if (dwell_cnt < DWELL) begin
                dwell_cnt <= dwell_cnt + DWELL_ONE;
              end else begin
                dwell_cnt <= '0;
                if (mode_s == MODE_SAW_DN) begin
                  data_q     <= LIMIT_HI;
                  trig_top_q <= 1'b1;
                  state_q    <= RAMP_DOWN;
                  dir_q      <= 1'b1;
                end else begin
                  data_q     <= up_res;
                  dir_q      <= 1'b0;
                  trig_top_q <= up_hit;
                  state_q    <= up_hit ? DWELL_TOP : RAMP_UP;
                end
              end
            end
            default: state_q <= RAMP_UP;
          endcase
        end
      end
    end
  end

  assign DATA     = data_q;
  assign DIR      = dir_q;
  assign TRIG_TOP = trig_top_q;
  assign TRIG_BOT = trig_bot_q;

`ifdef LED_SWEEP_GAMMA_EN
  logic [2*WIDTH-1:0] sq;
  logic [WIDTH-1:0]   gam_q;

  assign sq = {{WIDTH{1'b0}}, data_q} * {{WIDTH{1'b0}}, data_q};

  always_ff @(posedge CLOCK_IN or posedge RESET) begin
    if (RESET) gam_q <= '0;
    else       gam_q <= sq[2*WIDTH-1:WIDTH];
  end

  assign DATA_GAM = gam_q;
`else
  assign DATA_GAM = data_q;
`endif

endmodule
